// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types and constants for the board run/step controller.
// Holds the FSM state encoding, the button function indices and a small
// helper for sizing down-counters.
package dbg_pkg;

  // Encoding is visible on the state port and the debug display.
  typedef enum logic [1:0] {
    RESET = 2'd0,
    HALT  = 2'd1,
    RUN   = 2'd2,
    STEP  = 2'd3
  } dbg_state_t;

  // Button function indices into the btn vector.
  localparam int BTN_RUN   = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_BURST = 2;
  localparam int BTN_RST   = 3;

  // Number of button bits that carry a function.
  localparam int NUM_FUNC_BTN = 4;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one raw push-button in, a clean debounced level and a
// single-cycle press event out.
// The raw pin goes through a 2-flop synchronizer; the debounced level only
// follows the synchronized value after DEBOUNCE_CYCLES consecutive samples
// that all disagree with the current level. Releases produce no event.
module btn_debounce
  import dbg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic press
);

  // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic          deb_q;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip the level on the
  // last one; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Delayed level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= 1'b0;
    end else begin
      deb_q <= deb;
    end
  end

  // One-cycle event on the rising edge of the debounced level.
  assign press = deb & ~deb_q;

endmodule

// File: rtl/dbg_run_ctrl.sv
// dbg_run_ctrl: board-level run/step controller for the MIPS core.
// Debounces the push-buttons, turns them into single-cycle press events and
// sequences the core clock enable and reset through RESET/HALT/RUN/STEP.
// Also counts every enabled core cycle for the debug display.
//
// Build option: define DBG_RUN_CTRL_BURST_EN to make btn[2] start a burst of
// STEP_BURST core cycles. Without it btn[2] has no function, STEP always
// lasts one cycle and the burst counter is not built.
//
// The FSM state is exported on the state port; cpu_ce and cpu_rst are pure
// decodes of the state register, so they change exactly with the state.
module dbg_run_ctrl
  import dbg_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_BURST      = 16,
  parameter int RST_CYCLES      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               halt_req,
  output logic               cpu_ce,
  output logic               cpu_rst,
  output logic [1:0]         state,
  output logic [31:0]        step_cnt
);

  // One shared down-counter serves the RESET pulse and the STEP length.
`ifdef DBG_RUN_CTRL_BURST_EN
  localparam int CNT_MAX = (STEP_BURST > RST_CYCLES - 1) ? STEP_BURST : RST_CYCLES - 1;
`else
  localparam int CNT_MAX = RST_CYCLES - 1;
  localparam int unused_step_burst = STEP_BURST;
`endif
  localparam int            CW       = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef DBG_RUN_CTRL_BURST_EN
  localparam logic [CW-1:0] BURST_LOAD = CW'(STEP_BURST);
`endif

  logic [NUM_BTN-1:0] deb_vec;
  logic [NUM_BTN-1:0] press_vec;
  logic [NUM_FUNC_BTN-1:0] ev;
  logic               unused_bits;

  dbg_state_t    state_q;
  dbg_state_t    state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [31:0]   step_cnt_q;

  // Every button gets its own synchronizer and debouncer, including any
  // extra bits beyond the four functional ones.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn[i]),
      .deb  (deb_vec[i]),
      .press(press_vec[i])
    );
  end

  assign ev = press_vec[NUM_FUNC_BTN-1:0];

  // Levels and extra/no-function events are deliberately left unconsumed.
  assign unused_bits = ^{deb_vec, press_vec};

  // State and shared counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      cnt_q   <= RST_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. Priority: core-reset button, then a breakpoint halt
  // while the core is clocked, then the per-state button/counter rules.
  // Events that match no rule are dropped, never queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ev[BTN_RST]) begin
      state_d = RESET;
      cnt_d   = RST_LOAD;
    end else if (halt_req && (state_q == RUN || state_q == STEP)) begin
      // Breakpoint wins over anything else; a running burst is abandoned.
      state_d = HALT;
    end else begin
      unique case (state_q)
        RESET: begin
          if (cnt_q == '0) begin
            state_d = HALT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HALT: begin
          // A held breakpoint blocks RUN but still allows stepping past it.
          if (ev[BTN_RUN] && !halt_req) begin
            state_d = RUN;
          end else if (ev[BTN_STEP]) begin
            state_d = STEP;
            cnt_d   = CNT_ONE;
          end
`ifdef DBG_RUN_CTRL_BURST_EN
          else if (ev[BTN_BURST]) begin
            state_d = STEP;
            cnt_d   = BURST_LOAD;
          end
`endif
        end
        RUN: begin
          if (ev[BTN_RUN]) begin
            state_d = HALT;
          end
        end
        STEP: begin
`ifdef DBG_RUN_CTRL_BURST_EN
          // Count holds the cycles left including this one.
          if (ev[BTN_RUN] || cnt_q == CNT_ONE) begin
            state_d = HALT;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
`else
          // Single step only: always one enabled cycle.
          state_d = HALT;
`endif
        end
        default: begin
          state_d = RESET;
          cnt_d   = RST_LOAD;
        end
      endcase
    end
  end

  // Enabled-cycle counter; wraps naturally, cleared on entry to RESET.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
    end else if (ev[BTN_RST]) begin
      step_cnt_q <= '0;
    end else if (cpu_ce) begin
      step_cnt_q <= step_cnt_q + 32'd1;
    end
  end

  assign cpu_ce   = (state_q == RUN) || (state_q == STEP);
  assign cpu_rst  = (state_q == RESET);
  assign state    = state_q;
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// tb_dbg_run_ctrl: directed table, hand-written corner sequences and
// randomized button traffic against a window-based reference model.
// Honours DBG_RUN_CTRL_BURST_EN the same way as the design.
module tb_dbg_run_ctrl;

  localparam int DEB = 4;
  localparam int SB  = 5;
  localparam int RC  = 3;

`ifdef DBG_RUN_CTRL_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  localparam int M_RESET = 0;
  localparam int M_HALT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_STEP  = 3;

  logic        clk;
  logic        rst;
  logic [3:0]  btn;
  logic        halt_req;
  logic        cpu_ce;
  logic        cpu_rst;
  logic [1:0]  state;
  logic [31:0] step_cnt;

  int n_chk;
  int n_pass;
  bit chk_on;

  dbg_run_ctrl #(
    .NUM_BTN        (4),
    .DEBOUNCE_CYCLES(DEB),
    .STEP_BURST     (SB),
    .RST_CYCLES     (RC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .halt_req(halt_req),
    .cpu_ce  (cpu_ce),
    .cpu_rst (cpu_rst),
    .state   (state),
    .step_cnt(step_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Debounced level flips when the last DEB synchronized samples (raw
  // samples from two cycles back) all agree on the other value. FSM is
  // tracked as a mode plus the number of cycles left in that mode.
  logic [3:0]  hist[$];
  logic [3:0]  m_deb;
  logic [3:0]  m_deb_prev;
  int          m_mode;
  int          m_left;
  logic [31:0] m_step;

  always @(posedge clk) begin
    logic [3:0] pr;
    logic [3:0] nd;
    logic       v;
    logic       same;
    if (rst) begin
      hist.delete();
      for (int k = 0; k < DEB + 2; k++) hist.push_back(4'b0);
      m_deb      = 4'b0;
      m_deb_prev = 4'b0;
      m_mode     = M_RESET;
      m_left     = RC;
      m_step     = 32'd0;
    end else begin
      pr = m_deb & ~m_deb_prev;
      if (m_mode == M_RUN || m_mode == M_STEP) m_step = m_step + 32'd1;
      if (pr[3]) begin
        m_mode = M_RESET;
        m_left = RC;
        m_step = 32'd0;
      end else if (halt_req && (m_mode == M_RUN || m_mode == M_STEP)) begin
        m_mode = M_HALT;
      end else begin
        case (m_mode)
          M_HALT: begin
            if (pr[0] && !halt_req) m_mode = M_RUN;
            else if (pr[1]) begin m_mode = M_STEP; m_left = 1; end
            else if (BURST_ON && pr[2]) begin m_mode = M_STEP; m_left = SB; end
          end
          M_RUN: if (pr[0]) m_mode = M_HALT;
          M_STEP: begin
            if (pr[0]) m_mode = M_HALT;
            else begin
              m_left = m_left - 1;
              if (m_left == 0) m_mode = M_HALT;
            end
          end
          default: begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_HALT;
          end
        endcase
      end
      hist.push_back(btn);
      void'(hist.pop_front());
      nd = m_deb;
      for (int i = 0; i < 4; i++) begin
        v = hist[0][i];
        same = 1'b1;
        for (int j = 1; j < DEB; j++) if (hist[j][i] !== v) same = 1'b0;
        if (same && v !== m_deb[i]) nd[i] = v;
      end
      m_deb_prev = m_deb;
      m_deb      = nd;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] es;
    logic       ece;
    logic       erst;
    if (chk_on) begin
      es   = 2'(m_mode);
      ece  = (m_mode == M_RUN) || (m_mode == M_STEP);
      erst = (m_mode == M_RESET);
      n_chk++;
      if (state === es && cpu_ce === ece && cpu_rst === erst && step_cnt === m_step) begin
        n_pass++;
      end else begin
        $display("FAIL model t=%0t: state/ce/rst/cnt got %0d/%0b/%0b/%0h expected %0d/%0b/%0b/%0h",
                 $time, state, cpu_ce, cpu_rst, step_cnt, es, ece, erst, m_step);
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] b, input logic h, input int cycles);
    btn      = b;
    halt_req = h;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  b;
    logic        h;
    int          cycles;
    logic [1:0]  st;
    logic [31:0] sc;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] b, input logic h, input int cycles,
                              input logic [1:0] st, input logic [31:0] sc, input string name);
    vec_t v;
    v.b = b; v.h = h; v.cycles = cycles; v.st = st; v.sc = sc; v.name = name;
    tbl.push_back(v);
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [31:0] bs;
    n_chk    = 0;
    n_pass   = 0;
    chk_on   = 1'b0;
    rst      = 1'b1;
    btn      = 4'b0;
    halt_req = 1'b0;

    bs = BURST_ON ? 32'd1 + SB : 32'd1;
    add(4'h0, 0, 2,  2'd0, 0,       "rst_hold");
    add(4'h0, 0, 1,  2'd1, 0,       "rst_to_halt");
    add(4'h2, 0, 10, 2'd1, 1,       "single_step");
    add(4'h0, 0, 10, 2'd1, 1,       "step_release");
    add(4'h2, 0, 3,  2'd1, 1,       "glitch_hold");
    add(4'h0, 0, 10, 2'd1, 1,       "glitch_none");
    add(4'h4, 0, 12, 2'd1, bs,      "burst");
    add(4'h0, 0, 10, 2'd1, bs,      "burst_release");
    add(4'h1, 0, 26, 2'd2, bs + 19, "run");
    add(4'h1, 1, 1,  2'd1, bs + 20, "run_halt");
    add(4'h0, 1, 10, 2'd1, bs + 20, "halt_release");
    add(4'h1, 1, 10, 2'd1, bs + 20, "run_blocked");
    add(4'h0, 0, 10, 2'd1, bs + 20, "blocked_release");
    add(4'h1, 0, 10, 2'd2, bs + 23, "run_again");
    add(4'h0, 0, 10, 2'd2, bs + 33, "run_release");
    add(4'h8, 0, 7,  2'd0, 0,       "core_rst");
    add(4'h8, 0, 2,  2'd0, 0,       "core_rst_hold");
    add(4'h8, 0, 1,  2'd1, 0,       "core_rst_done");
    add(4'h0, 0, 10, 2'd1, 0,       "core_rst_release");
    add(4'h9, 0, 7,  2'd0, 0,       "rst_beats_run");
    add(4'h9, 0, 2,  2'd0, 0,       "rst_beats_run_hold");
    add(4'h9, 0, 1,  2'd1, 0,       "rst_beats_run_done");
    add(4'h0, 0, 10, 2'd1, 0,       "dual_release");

    // Reset values while rst is held.
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset_cpu_ce", 32'(cpu_ce), 32'd0);
    check("reset_step_cnt", step_cnt, 32'd0);
    chk_on = 1'b1;
    rst    = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].b, tbl[i].h, tbl[i].cycles);
      check({tbl[i].name, "_state"}, 32'(state), 32'(tbl[i].st));
      check({tbl[i].name, "_cnt"}, step_cnt, tbl[i].sc);
    end

    // Burst cut short by a breakpoint raised on its third STEP cycle.
    drive(4'h4, 0, 9);
    drive(4'h4, 1, 1);
    check("burst_halt_state", 32'(state), 32'd1);
    check("burst_halt_cnt", step_cnt, BURST_ON ? 32'd3 : 32'd0);
    drive(4'h0, 0, 10);

    // Counter wrap: preload near the top, then run three cycles.
    force dut.step_cnt_q = 32'hFFFF_FFFE;
    m_step = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.step_cnt_q;
    @(posedge clk);
    #1;
    drive(4'h1, 0, 9);
    drive(4'h1, 1, 1);
    check("wrap_state", 32'(state), 32'd1);
    check("wrap_cnt", step_cnt, 32'd1);
    drive(4'h0, 0, 10);

    // Randomized button traffic with occasional breakpoints and resets.
    for (int s = 0; s < 250; s++) begin
      int r;
      logic [3:0] b;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        rst = 1'b1;
        drive(4'h0, 0, 2);
        rst = 1'b0;
      end else begin
        if (r < 13) b = 4'(1 << $urandom_range(0, 2));
        else if (r < 14) b = 4'h8;
        else if (r < 16) b = 4'($urandom_range(0, 15));
        else b = 4'h0;
        drive(b, $urandom_range(0, 4) == 0, $urandom_range(1, 12));
      end
    end
    drive(4'h0, 0, 4);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dbg_run_ctrl.md
# dbg_run_ctrl

Board-level run/step controller for the MIPS core: debounces the raw push-buttons, converts them to single-cycle edge events and sequences the core's clock enable and reset through a RESET/HALT/RUN/STEP state machine. It sits between the board button pins and the core's `ce`/`rst` inputs. It also counts every enabled core cycle for the seven-segment/LED debug display.

## Interface
Parameters:
- NUM_BTN, 4, number of raw buttons; functions map to bits 0..3, any extra bits are debounced but unused.
- DEBOUNCE_CYCLES, 500000, number of consecutive stable synchronized samples required before the debounced level changes; minimum 1.
- STEP_BURST, 16, number of core cycles per burst step; minimum 1.
- RST_CYCLES, 8, length of the core reset pulse in cycles; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- btn  in  NUM_BTN  raw asynchronous buttons, active-high: [0] run/halt toggle, [1] single step, [2] burst step, [3] core reset.
- halt_req  in  1  level breakpoint/halt request from the core.
- cpu_ce  out  1  core clock enable.
- cpu_rst  out  1  core reset.
- state  out  2  current FSM state: RESET=0, HALT=1, RUN=2, STEP=3.
- step_cnt  out  32  count of cycles with cpu_ce=1.

## Operation
- Each button passes through a 2-flop synchronizer and then a debounce counter.
  - If the synchronized value equals the debounced value `deb`, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with the value still differing, `deb` takes the new value and the counter clears.
- Press event: `press[i] = deb[i] & ~deb_q[i]`, where `deb_q` is `deb` registered. It is one cycle wide per press. Releases generate no event.
- FSM transitions, evaluated in priority order within a cycle:
  - press[3] from any state: go to RESET and load the counter with RST_CYCLES-1.
  - halt_req=1 in RUN or STEP: go to HALT. Any remaining burst is abandoned.
  - press[0]: HALT to RUN, but only if halt_req=0. RUN to HALT. STEP to HALT.
  - press[1] in HALT: go to STEP with count 1.
  - press[2] in HALT: go to STEP with count STEP_BURST.
  - RESET: decrement the counter each cycle; when the counter is 0, go to HALT.
  - STEP: decrement the count each cycle; when the count is 1, go to HALT.
- Press events not listed above are dropped; they are not queued. This includes step or burst presses in RUN or STEP, and run presses in RESET.
- While halt_req is held, the core can still be stepped past the breakpoint in HALT, but cannot be placed in RUN.
- Outputs are decoded from the state register only:
  - cpu_ce = (state==RUN) | (state==STEP).
  - cpu_rst = (state==RESET).
- step_cnt increments on every cycle with cpu_ce=1 and wraps from 2^32-1 to 0. It is cleared on rst and on entry to RESET.
- Reset values: state=RESET, cpu_rst=1, cpu_ce=0, step_cnt=0, all `deb`/`deb_q`/synchronizer/debounce counters=0, RESET counter=RST_CYCLES-1.
  - After rst deasserts, RESET holds for RST_CYCLES cycles, then the FSM enters HALT.
  - If rst asserts mid-burst or mid-run, everything returns immediately to these reset values.

## Timing
- Raw button to debounced level: 2 + DEBOUNCE_CYCLES cycles of stable input.
- Press event is on the same cycle `deb` rises. The state changes on the next clock edge, and cpu_ce/cpu_rst change with the state, 1 cycle after the event.
- A STEP with count N holds cpu_ce high for exactly N consecutive cycles.
- halt_req sampled high at cycle t gives cpu_ce=0 from cycle t+1.
- A button press shorter than DEBOUNCE_CYCLES stable samples produces no event.

## Configuration
- DBG_RUN_CTRL_BURST_EN
  - Defined: btn[2] triggers burst stepping of STEP_BURST cycles.
  - Undefined: press[2] is ignored, STEP is entered only with count 1, the burst count logic is not built, and STEP_BURST is unused.

## Structure
- Shared package `dbg_pkg`:
  - `dbg_state_t` enum with RESET/HALT/RUN/STEP encoded 0..3.
  - Button index constants BTN_RUN=0, BTN_STEP=1, BTN_BURST=2, BTN_RST=3.
- Sub-module `btn_debounce`, instantiated once per button.
  - Parameter: DEBOUNCE_CYCLES.
  - Contents: synchronizer and debounce counter.
  - Outputs: `deb` and a one-cycle `press`.

## Test plan
Bench settings: DEBOUNCE_CYCLES=4, STEP_BURST=5, RST_CYCLES=3.
- Reset release -> cpu_rst=1 for 3 cycles, then state=HALT, cpu_ce=0, step_cnt=0.
- btn[1] held 10 cycles from HALT -> exactly 1 cycle of cpu_ce=1, step_cnt=1, return to HALT. A 3-cycle glitch on btn[1] -> no step.
- btn[2] from HALT -> 5 consecutive cpu_ce cycles, step_cnt=5. Repeat with halt_req asserted on the 3rd STEP cycle -> only 3 cycles counted.
- btn[0] press -> RUN. Assert halt_req after 20 cycles -> HALT on the next cycle, step_cnt=20. Press btn[0] while halt_req=1 -> stays in HALT.
- btn[3] in RUN -> RESET for 3 cycles, step_cnt cleared to 0, then HALT. Debounced press events on btn[3] and btn[0] in the same cycle -> RESET wins.
- Preload step_cnt to 2^32-2 via force, then RUN for 3 cycles -> step_cnt=1 (wrap).
